miriscv_mdu_seq: RTL
====================

MIRISCV_MDU_SEQ -- requirements
Module: miriscv_mdu_seq

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- XLEN, 32, operand and result width; legal values 8..64, even.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, never overridden.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, the single clock; all state changes on its rising edge.
- arstn_i, in, 1, asynchronous active-low reset.
- mdu_req_i, in, 1, operation request.
- mdu_op_i, in, 3, opcode: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- mdu_port_a_i, in, XLEN, operand A (multiplicand or dividend).
- mdu_port_b_i, in, XLEN, operand B (multiplier or divisor).
- mdu_kill_i, in, 1, abort the current operation.
- mdu_ready_o, out, 1, idle; a request is accepted this cycle.
- mdu_valid_o, out, 1, one-cycle pulse marking mdu_result_o valid.
- mdu_result_o, out, XLEN, result.

Function
REQ-003 The block SHALL implement the states IDLE, CALC and DONE, and mdu_ready_o SHALL equal (state==IDLE).
REQ-004 In IDLE with mdu_req_i=1 and mdu_kill_i=0 (the acceptance cycle, cycle 0), the block SHALL register the opcode, the operand magnitudes and the result sign.
REQ-005 The block SHALL ignore mdu_req_i and input changes in every state other than IDLE.
REQ-006 On normal acceptance, the transition SHALL be IDLE->CALC, with the counter loaded to XLEN.
REQ-007 In CALC, the block SHALL process one operand bit per cycle and decrement the counter; it SHALL move to DONE when the counter reaches 1. CALC occupies cycles 1..XLEN.
REQ-008 In DONE (cycle XLEN+1), the block SHALL drive mdu_valid_o=1 for exactly one cycle and then return to IDLE; for XLEN=32 the result is valid in cycle 33.
REQ-009 Multiplication SHALL use unsigned shift-add on the magnitudes into a 2*XLEN accumulator, with the product negated in DONE when the sign is set.
- MUL: low XLEN bits.
- MULH: high XLEN bits, signed x signed.
- MULHSU: high XLEN bits, A signed x B unsigned.
- MULHU: high XLEN bits, unsigned.
REQ-010 Division SHALL be restoring division on the magnitudes, truncating toward zero.
- Quotient sign = sign(A) xor sign(B).
- Remainder sign = sign(A).
REQ-011 When the divisor is zero, the block SHALL take the fast path IDLE->DONE with valid in cycle 1.
- DIV/DIVU: result all ones.
- REM/REMU: result = A.
REQ-012 For signed overflow (A = most negative, B = -1, DIV/REM only), the block SHALL take the fast path with valid in cycle 1.
- DIV: result = A.
- REM: result = 0.
REQ-013 mdu_kill_i=1 in CALC or DONE SHALL force IDLE at the next edge and suppress mdu_valid_o in that cycle.
REQ-014 mdu_kill_i=1 together with mdu_req_i=1 in IDLE SHALL leave the request unaccepted; kill has priority.
REQ-015 mdu_result_o SHALL hold its last value outside DONE. A new request SHALL be accepted only in the cycle after DONE, when the block is back in IDLE; the back-to-back issue rate is XLEN+2 cycles.

Reset
REQ-016 Assertion of arstn_i=0 SHALL, immediately and regardless of clk_i, set:
- state=IDLE;
- mdu_valid_o=0;
- mdu_result_o=0;
- the counter and all datapath registers to 0;
- mdu_ready_o=1.
REQ-017 Reset asserted mid-CALC SHALL discard the operation, produce no valid pulse after release, and leave the block accepting a new request in the first cycle after deassertion.

Verification
REQ-018 MUL, A=7, B=0xFFFFFFFD -> result 0xFFFFFFEB; valid in cycle 33 only.
REQ-019 Multiply-high checks:
- MULH, A=B=0x80000000 -> 0x40000000.
- MULHSU, A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF.
- MULHU, same operands -> 0xFFFFFFFE.
REQ-020 DIV, A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU, A=100, B=7 -> 14. REMU with the same operands -> 2.
REQ-021 Fast-path checks, valid in cycle 1:
- DIVU, A=5, B=0 -> 0xFFFFFFFF.
- REM, A=5, B=0 -> 5.
- DIV, A=0x80000000, B=0xFFFFFFFF -> 0x80000000.
- REM, same operands -> 0.
REQ-022 Kill and reset checks:
- mdu_kill_i pulsed in cycle 10 of a DIV -> no valid; mdu_ready_o=1 in cycle 11; a MUL 3x4 issued in cycle 11 -> 12 in cycle 44.
- kill+req in IDLE -> not accepted.
REQ-023 arstn_i dropped asynchronously mid-CALC -> outputs zero at once and mdu_ready_o=1; after release, no spurious valid and a new op completes correctly.
REQ-024 Re-run REQ-018..REQ-021 at XLEN=16 with equivalent 16-bit values; expected latency is 17 cycles on the normal path and 1 cycle on the fast path.

Source files
------------

// File: rtl/miriscv_mdu_seq.sv
// Sequential RISC-V M-extension unit: one-bit-per-cycle shift-add multiply and
// restoring divide on operand magnitudes, with single-cycle fast paths for
// divide-by-zero and signed overflow.
module miriscv_mdu_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            mdu_req_i,
    input  logic [2:0]      mdu_op_i,
    input  logic [XLEN-1:0] mdu_port_a_i,
    input  logic [XLEN-1:0] mdu_port_b_i,
    input  logic            mdu_kill_i,
    output logic            mdu_ready_o,
    output logic            mdu_valid_o,
    output logic [XLEN-1:0] mdu_result_o
);

    localparam int unsigned AW = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             sign_q, sign_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             valid_q, valid_d;

    logic            is_div_in;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            sign_in;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] fast_res;

    logic [XLEN:0]   mul_sum;
    logic [AW-1:0]   acc_mul;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;
    logic [AW-1:0]   acc_div;
    logic [AW-1:0]   acc_step;
    logic [AW-1:0]   prod_fin;
    logic [XLEN-1:0] mul_res;
    logic [XLEN-1:0] div_sel;
    logic [XLEN-1:0] div_res;
    logic [XLEN-1:0] final_res;

    // Request decode: operand signedness, magnitudes, result sign, fast-path cases
    always_comb begin
        is_div_in = mdu_op_i[2];
        a_neg     = 1'b0;
        b_neg     = 1'b0;
        sign_in   = 1'b0;
        case (mdu_op_i)
            OP_MULH: begin
                a_neg   = mdu_port_a_i[XLEN-1];
                b_neg   = mdu_port_b_i[XLEN-1];
                sign_in = a_neg ^ b_neg;
            end
            OP_MULHSU: begin
                a_neg   = mdu_port_a_i[XLEN-1];
                sign_in = a_neg;
            end
            OP_DIV: begin
                a_neg   = mdu_port_a_i[XLEN-1];
                b_neg   = mdu_port_b_i[XLEN-1];
                sign_in = a_neg ^ b_neg;
            end
            OP_REM: begin
                a_neg   = mdu_port_a_i[XLEN-1];
                b_neg   = mdu_port_b_i[XLEN-1];
                sign_in = a_neg;
            end
            default: begin
                a_neg   = 1'b0;
                b_neg   = 1'b0;
                sign_in = 1'b0;
            end
        endcase
        a_mag    = a_neg ? -mdu_port_a_i : mdu_port_a_i;
        b_mag    = b_neg ? -mdu_port_b_i : mdu_port_b_i;
        div_zero = is_div_in && (mdu_port_b_i == '0);
        div_ovf  = ((mdu_op_i == OP_DIV) || (mdu_op_i == OP_REM)) &&
                   (mdu_port_a_i == MIN_NEG) && (mdu_port_b_i == '1);
        if (div_zero) begin
            fast_res = mdu_op_i[1] ? mdu_port_a_i : '1;
        end else begin
            fast_res = mdu_op_i[1] ? '0 : mdu_port_a_i;
        end
    end

    // One iteration of shift-add multiply or restoring divide, plus final sign fix-up
    always_comb begin
        mul_sum   = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        acc_mul   = {mul_sum, acc_q[XLEN-1:1]};

        div_shift = acc_q[AW-1:XLEN-1];
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[XLEN-1:0] - opnd_q;
        acc_div   = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

        acc_step  = op_q[2] ? acc_div : acc_mul;

        prod_fin  = sign_q ? -acc_step : acc_step;
        mul_res   = (op_q[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[AW-1:XLEN];
        div_sel   = op_q[1] ? acc_step[AW-1:XLEN] : acc_step[XLEN-1:0];
        div_res   = sign_q ? -div_sel : div_sel;
        final_res = op_q[2] ? div_res : mul_res;
    end

    // Control FSM: accept in IDLE, iterate in CALC, present result in DONE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_d   = sign_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mdu_req_i && !mdu_kill_i) begin
                    op_d   = mdu_op_i;
                    sign_d = sign_in;
                    if (div_zero || div_ovf) begin
                        result_d = fast_res;
                        valid_d  = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        opnd_d  = is_div_in ? b_mag : a_mag;
                        acc_d   = {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
                        cnt_d   = CNT_W'(XLEN);
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (mdu_kill_i) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_d = final_res;
                        valid_d  = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    // A kill during DONE drops the pulse in that same cycle
    assign mdu_ready_o  = (state_q == ST_IDLE);
    assign mdu_valid_o  = valid_q & ~mdu_kill_i;
    assign mdu_result_o = result_q;

endmodule
